// File: rtl/roll_pkg.sv
// Shared types and default timing constants for the roll scheduler.
package roll_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} roll_state_e;

  localparam int DEF_PERIOD_W     = 26;
  localparam int DEF_BASE_PERIOD  = 2_500_000;
  localparam int DEF_MAX_PERIOD   = 50_000_000;
  localparam int DEF_GROWTH_SHIFT = 3;
  localparam int DEF_NUM_STEPS    = 16;
endpackage

// File: rtl/roll_interval_counter.sv
// Interval counter for one roll: counts toward the effective interval and grows
// the period by a saturating fraction of itself after every expiry.
module roll_interval_counter
  import roll_pkg::*;
#(
  parameter int PERIOD_W     = DEF_PERIOD_W,
  parameter int BASE_PERIOD  = DEF_BASE_PERIOD,
  parameter int MAX_PERIOD   = DEF_MAX_PERIOD,
  parameter int GROWTH_SHIFT = DEF_GROWTH_SHIFT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_run,
  input  logic i_fast,
  output logic o_expire
);
  localparam logic [PERIOD_W-1:0] BASE = PERIOD_W'(BASE_PERIOD);
  localparam logic [PERIOD_W-1:0] MAXP = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE  = PERIOD_W'(1);

  logic [PERIOD_W-1:0] r_cnt, r_period;
  logic [PERIOD_W-1:0] w_half, w_eff, w_inc, w_period_nxt;
  logic [PERIOD_W:0]   w_sum;

  always_comb begin
    w_half = r_period >> 1;
    w_eff  = i_fast ? ((w_half == '0) ? ONE : w_half) : r_period;
    w_inc  = r_period >> GROWTH_SHIFT;
    if (w_inc == '0) w_inc = ONE;
    w_sum        = {1'b0, r_period} + {1'b0, w_inc};
    w_period_nxt = (w_sum >= {1'b0, MAXP}) ? MAXP : w_sum[PERIOD_W-1:0];
  end

  // >= rather than == so a count already past a freshly halved interval fires at once
  assign o_expire = i_run && (r_cnt >= w_eff - ONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_period <= BASE;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_period <= BASE;
    end else if (i_run) begin
      if (o_expire) begin
        r_cnt    <= '0;
        r_period <= w_period_nxt;
      end else begin
        r_cnt <= r_cnt + ONE;
      end
    end
  end
endmodule

// File: rtl/roll_scheduler.sv
// Roll sequencer: issues a decelerating train of advance ticks after a start,
// with pause/resume, speedup and restart handling.
module roll_scheduler
  import roll_pkg::*;
#(
  parameter int PERIOD_W     = DEF_PERIOD_W,
  parameter int BASE_PERIOD  = DEF_BASE_PERIOD,
  parameter int MAX_PERIOD   = DEF_MAX_PERIOD,
  parameter int GROWTH_SHIFT = DEF_GROWTH_SHIFT,
  parameter int NUM_STEPS    = DEF_NUM_STEPS
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_pause,
  input  logic                           i_speedup,
  output logic                           o_tick,
  output logic                           o_done,
  output logic                           o_busy,
  output logic                           o_paused,
  output logic [$clog2(NUM_STEPS+1)-1:0] o_step
);
  localparam int STEP_W = $clog2(NUM_STEPS + 1);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS);

  roll_state_e       r_state, w_state_nxt;
  logic              r_fast, w_fast_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic              r_tick, w_tick, r_done, w_done;
  logic              w_expire, w_final;

  roll_interval_counter #(
    .PERIOD_W    (PERIOD_W),
    .BASE_PERIOD (BASE_PERIOD),
    .MAX_PERIOD  (MAX_PERIOD),
    .GROWTH_SHIFT(GROWTH_SHIFT)
  ) u_interval (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_start),
    .i_run   (r_state == RUN),
    .i_fast  (r_fast),
    .o_expire(w_expire)
  );

  assign w_final = w_expire && (r_step + STEP_W'(1) == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_fast_nxt  = r_fast;
    w_step_nxt  = r_step;
    w_tick      = 1'b0;
    w_done      = 1'b0;
    if (i_start) begin
      // a final tick landing on the restart edge is still announced
      w_state_nxt = RUN;
      w_fast_nxt  = 1'b0;
      w_step_nxt  = '0;
      w_tick      = w_final;
      w_done      = w_final;
    end else begin
      case (r_state)
        RUN: begin
          if (w_expire) begin
            w_tick     = 1'b1;
            w_step_nxt = r_step + STEP_W'(1);
          end
          if (w_final) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else if (i_pause) begin
            w_state_nxt = PAUSE;
          end else if (i_speedup) begin
            w_fast_nxt = 1'b1;
          end
        end
        PAUSE: begin
          if (i_pause)        w_state_nxt = RUN;
          else if (i_speedup) w_fast_nxt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_fast  <= 1'b0;
      r_step  <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fast  <= w_fast_nxt;
      r_step  <= w_step_nxt;
      r_tick  <= w_tick;
      r_done  <= w_done;
    end
  end

  assign o_tick   = r_tick;
  assign o_done   = r_done;
  assign o_step   = r_step;
  assign o_busy   = (r_state != IDLE);
  assign o_paused = (r_state == PAUSE);
endmodule

// File: tb/tb_roll_scheduler.sv
// Directed bench for roll_scheduler: normal, paused, fast, restarted and
// saturating rolls plus asynchronous reset behaviour.
module tb_roll_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic a_start, a_pause, a_speed, a_tick, a_done, a_busy, a_paused;
  logic [2:0] a_step;
  logic b_start, b_pause, b_speed, b_tick, b_done, b_busy, b_paused;
  logic [1:0] b_step;

  int n_chk = 0, n_fail = 0;
  int e, nt;
  int pa, pb, sp, rs;
  int exp_q[$];

  always #5 clk = ~clk;

  roll_scheduler #(.BASE_PERIOD(8), .GROWTH_SHIFT(2), .NUM_STEPS(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_pause(a_pause),
    .i_speedup(a_speed), .o_tick(a_tick), .o_done(a_done), .o_busy(a_busy),
    .o_paused(a_paused), .o_step(a_step));

  roll_scheduler #(.BASE_PERIOD(8), .MAX_PERIOD(9), .GROWTH_SHIFT(3), .NUM_STEPS(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_pause(b_pause),
    .i_speedup(b_speed), .o_tick(b_tick), .o_done(b_done), .o_busy(b_busy),
    .o_paused(b_paused), .o_step(b_step));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: got %0d expected %0d", tag, e, got, expv);
    end
  endtask

  task automatic start_a();
    a_start = 1'b1;
    @(posedge clk); e = 0;
    @(negedge clk); a_start = 1'b0;
    nt = 0;
    chk("start_busy", a_busy, 1);
    chk("start_step", a_step, 0);
    chk("start_tick", a_tick, 0);
  endtask

  // advances DUT A to edge 'last', driving scheduled pulses and checking every cycle
  task automatic run_a(input int last);
    int n;
    bit et;
    while (e < last) begin
      n = e + 1;
      a_start = (n == rs);
      a_pause = (n == pa) || (n == pb);
      a_speed = (n == sp);
      @(posedge clk); e = n;
      @(negedge clk);
      a_start = 1'b0; a_pause = 1'b0; a_speed = 1'b0;
      if (n == rs) nt = 0;
      et = 1'b0;
      foreach (exp_q[i]) if (exp_q[i] == e) et = 1'b1;
      if (et) nt++;
      chk("tick", a_tick, et);
      chk("step", a_step, nt);
      chk("done", a_done, et && (e == exp_q[$]));
      chk("busy", a_busy, e < exp_q[$]);
      chk("paused", a_paused, (pa >= 0) && (e >= pa) && ((pb < 0) || (e < pb)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_pause = 0; a_speed = 0;
    b_start = 0; b_pause = 0; b_speed = 0;
    e = 0; nt = 0;
    @(negedge clk);
    chk("rst_tick", a_tick, 0);   chk("rst_done", a_done, 0);
    chk("rst_busy", a_busy, 0);   chk("rst_paused", a_paused, 0);
    chk("rst_step", a_step, 0);   chk("rst_b_busy", b_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // plain roll: periods 8,10,12,15
    pa = -1; pb = -1; sp = -1; rs = -1;
    exp_q = '{8, 18, 30, 45};
    start_a(); run_a(48);

    // pause edges 5 and 25 push the train out by 20 cycles
    pa = 5; pb = 25;
    exp_q = '{28, 38, 50, 65};
    start_a(); run_a(68);

    // speedup at edge 2: eff 4,5,6,7
    pa = -1; pb = -1; sp = 2;
    exp_q = '{4, 9, 15, 22};
    start_a(); run_a(25);

    // restart at edge 20 aborts the tick due at 30
    sp = -1; rs = 20;
    exp_q = '{8, 18, 28, 38, 50, 65};
    start_a(); run_a(68);

    // saturating instance: periods 8,9,9
    b_start = 1'b1;
    @(posedge clk); e = 0;
    @(negedge clk); b_start = 1'b0; nt = 0;
    for (int k = 1; k <= 28; k++) begin
      bit et;
      @(posedge clk); e = k;
      @(negedge clk);
      et = (k == 8) || (k == 17) || (k == 26);
      if (et) nt++;
      chk("b_tick", b_tick, et);
      chk("b_step", b_step, nt);
      chk("b_done", b_done, k == 26);
      chk("b_busy", b_busy, k < 26);
    end

    // asynchronous reset while paused after one tick
    rs = -1; pa = 10; pb = -1;
    exp_q = '{8, 100};
    start_a(); run_a(12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", a_busy, 0);   chk("arst_paused", a_paused, 0);
    chk("arst_step", a_step, 0);   chk("arst_tick", a_tick, 0);
    chk("arst_done", a_done, 0);
    @(negedge clk); rst_n = 1'b1;

    // pause and speedup are ignored in IDLE
    a_pause = 1'b1;
    @(posedge clk); @(negedge clk); a_pause = 1'b0;
    chk("idle_pause_busy", a_busy, 0);
    chk("idle_pause_paused", a_paused, 0);
    a_speed = 1'b1;
    @(posedge clk); @(negedge clk); a_speed = 1'b0;
    chk("idle_speed_busy", a_busy, 0);
    chk("idle_speed_step", a_step, 0);

    // a fresh roll after reset follows the base schedule
    pa = -1;
    exp_q = '{8, 18, 30, 45};
    start_a(); run_a(47);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
